lvshift_bank_seq: RTL and testbench
===================================

# lvshift_bank_seq

Parametrised bank controller for N_CH 1.8 V→3.3 V level-shift channels plus N_CH 3.3 V→1.8 V return channels, sharing one power-down control. It sequences the analog shifter bank's PD pin through timed power-up and power-down settle windows. The forward outputs are clamped low whenever the bank is not fully up, and return inputs are synchronised and gated the same way. It sits at the digital/analog boundary in the 1.8 V domain, between core logic and the analog shifter cells.

## Interface
- N_CH, 8: number of forward channels and return channels (≥1).
- SETTLE_CYC, 16: CLK cycles spent in each of PWRUP and PWRDN (≥1).
- SYNC_STAGES, 2: flop stages on the return path (≥2).
- CLK  in  1  bank clock, 1.8 V domain.
- RSTN  in  1  asynchronous, active-low reset.
- EN  in  1  bank enable request, level-sensitive.
- A  in  N_CH  forward data from core logic.
- Y  out  N_CH  forward data to the shifter inputs; registered, clamped to 0 unless ON.
- PD  out  1  shifter power-down, active high; registered.
- AIN  in  N_CH  return data from the 3.3→1.8 shifters; asynchronous to CLK.
- AOUT  out  N_CH  synchronised return data; 0 unless ON.
- RDY  out  1  high iff state is ON.
- BUSY  out  1  high iff state is PWRUP or PWRDN.

## Operation
- States: OFF, PWRUP, ON, PWRDN. Reset puts the FSM in OFF. Reset values: PD=1, Y=0, AOUT=0, RDY=0, BUSY=0, counter=0, all synchroniser flops=0.
- OFF: PD=1. If EN=1, go to PWRUP and clear the counter.
- PWRUP: PD=0. Counter increments each cycle.
  - When counter reaches SETTLE_CYC-1 and EN=1, go to ON.
  - If EN=0 on any PWRUP cycle, abort to PWRDN with the counter cleared.
- ON: PD=0. Y <= A every cycle. AOUT = synchroniser output. If EN=0, go to PWRDN and clear the counter.
- PWRDN: PD stays 0 and Y is 0. After SETTLE_CYC cycles, go to OFF and set PD=1.
  - EN is ignored during PWRDN; the window always completes.
  - If EN=1 on arrival in OFF, PWRUP starts on the next edge.
- Y register: Y <= (next_state==ON) ? A : 0.
- Return path: AIN passes through SYNC_STAGES flops, always clocked. AOUT = (state==ON) ? sync_out : 0.
- Counter width is $clog2(SETTLE_CYC+1). It saturates and never wraps.

## Timing
- EN sampled high at edge 0 (state OFF): PD falls after edge 0, BUSY=1.
- Edge SETTLE_CYC: state becomes ON, RDY=1, BUSY=0, and Y carries A as sampled at that edge.
- Forward latency while ON: 1 cycle from A to Y.
- Return latency: SYNC_STAGES cycles from AIN to AOUT (plus the filter delay when enabled).
- EN sampled low at edge k while ON: RDY=0 and Y=0 after edge k; PD rises after edge k+SETTLE_CYC.
- A RSTN assertion in any state forces the reset values immediately (PD=1 asynchronously). This also applies mid-PWRUP and mid-PWRDN.

## Configuration
- LVSHIFT_RET_FILTER_EN defined: each return channel has a 2-cycle deglitch stage after the synchroniser.
  - AOUT bit changes only after sync_out holds the new value for 2 consecutive cycles.
  - Return latency becomes SYNC_STAGES+2.
  - Filter state resets to 0 and is held at 0 while not ON.
- LVSHIFT_RET_FILTER_EN undefined: no filter, and AOUT follows sync_out directly.

## Structure
- Package lvshift_pkg holds:
  - typedef enum logic [1:0] lvs_state_t: OFF=2'b00, PWRUP=2'b01, ON=2'b10, PWRDN=2'b11.
  - Default parameter constants.
- Sub-module lvshift_sync: N-bit, SYNC_STAGES-deep synchroniser with CLK/RSTN. Instantiated once for the return path.
- FSM, counter, Y register and the optional filter stay in lvshift_bank_seq.

## Test plan
- Reset with A=8'hFF and AIN=8'hFF → PD=1, Y=0, AOUT=0, RDY=0, BUSY=0.
- SETTLE_CYC=16, EN high at edge 0, A=8'hA5 → PD=0 after edge 0; RDY=1 and Y=8'hA5 after edge 16; Y=0 before that.
- In ON, drop EN at edge k → Y=0 and RDY=0 after edge k; PD=1 exactly after edge k+16. Pulse EN high at k+5 → ignored, PD still rises at k+16.
- Drop EN at PWRUP cycle 7 → PWRDN, PD rises 16 cycles later, RDY never asserts.
- In ON, step AIN 8'h00→8'h3C → AOUT=8'h3C after SYNC_STAGES edges. With the filter enabled: after SYNC_STAGES+2 edges, and a 1-cycle AIN glitch never reaches AOUT.
- Assert RSTN=0 mid-PWRUP → PD=1 immediately without waiting for a clock edge; after release, the FSM is in OFF.

Source files
------------

// File: rtl/lvshift_pkg.sv
// rtl/lvshift_pkg.sv - shared types and default parameters for the level-shift bank controller
// Contents:
//   lvs_state_t          bank power state encoding (OFF, PWRUP, ON, PWRDN)
//   LVS_*_DEF constants  default parameter values for the bank and synchroniser
package lvshift_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        PWRUP = 2'b01,
        ON    = 2'b10,
        PWRDN = 2'b11
    } lvs_state_t;

    localparam int unsigned LVS_N_CH_DEF        = 8;
    localparam int unsigned LVS_SETTLE_CYC_DEF  = 16;
    localparam int unsigned LVS_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/lvshift_sync.sv
// rtl/lvshift_sync.sv - multi-bit flop-chain synchroniser for the 3.3V->1.8V return channels
// Parameters: WIDTH bits wide, STAGES flops deep (>=2)
// Ports:
//   CLK   in          destination clock
//   RSTN  in          asynchronous active-low reset, clears every stage
//   d_i   in  WIDTH   asynchronous input data
//   q_o   out WIDTH   synchronised data, STAGES cycles behind d_i
module lvshift_sync
    import lvshift_pkg::*;
#(
    parameter int unsigned WIDTH  = LVS_N_CH_DEF,
    parameter int unsigned STAGES = LVS_SYNC_STAGES_DEF
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/lvshift_bank_seq.sv
// rtl/lvshift_bank_seq.sv - power sequencer and data gating for a bank of 1.8V<->3.3V level shifters
// Optional feature macro: LVSHIFT_RET_FILTER_EN (2-cycle deglitch on each return channel)
// Ports:
//   CLK   in          bank clock (1.8V domain)
//   RSTN  in          asynchronous active-low reset
//   EN    in          bank enable request, level-sensitive
//   A     in  N_CH    forward data from core
//   Y     out N_CH    forward data to shifters, registered, 0 unless ON
//   PD    out         shifter power-down, active high, registered
//   AIN   in  N_CH    return data from shifters, asynchronous
//   AOUT  out N_CH    synchronised return data, 0 unless ON
//   RDY   out         state is ON
//   BUSY  out         state is PWRUP or PWRDN
module lvshift_bank_seq
    import lvshift_pkg::*;
#(
    parameter int unsigned N_CH        = LVS_N_CH_DEF,
    parameter int unsigned SETTLE_CYC  = LVS_SETTLE_CYC_DEF,
    parameter int unsigned SYNC_STAGES = LVS_SYNC_STAGES_DEF
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            EN,
    input  logic [N_CH-1:0] A,
    output logic [N_CH-1:0] Y,
    output logic            PD,
    input  logic [N_CH-1:0] AIN,
    output logic [N_CH-1:0] AOUT,
    output logic            RDY,
    output logic            BUSY
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYC);

    lvs_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  y_q;
    logic             pd_q;
    logic             rdy_q;
    logic             busy_q;
    logic [N_CH-1:0]  sync_out;
    logic [N_CH-1:0]  ret_data;

    // Next-state and settle counter. The counter only ever runs inside the
    // PWRUP/PWRDN windows and is cleared on every window entry and exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (EN) begin
                    state_d = PWRUP;
                end
            end
            PWRUP: begin
                // Dropping EN aborts immediately, even on the final settle cycle.
                if (!EN) begin
                    state_d = PWRDN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                cnt_d = '0;
                if (!EN) begin
                    state_d = PWRDN;
                end
            end
            PWRDN: begin
                // EN is deliberately ignored here so the analog cells always
                // get a full discharge window before power-down is reasserted.
                if (cnt_q == CNT_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= OFF;
            cnt_q   <= '0;
            y_q     <= '0;
            pd_q    <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= (state_d == ON) ? A : '0;
            pd_q    <= (state_d == OFF);
            rdy_q   <= (state_d == ON);
            busy_q  <= (state_d == PWRUP) || (state_d == PWRDN);
        end
    end

    lvshift_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_ret_sync (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d_i  (AIN),
        .q_o  (sync_out)
    );

`ifdef LVSHIFT_RET_FILTER_EN
    logic [N_CH-1:0] hist_q;
    logic [N_CH-1:0] filt_q;

    // A bit is accepted only when two consecutive synchroniser samples agree;
    // otherwise the previous filtered value is held.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hist_q <= '0;
            filt_q <= '0;
        end else if (state_q != ON) begin
            hist_q <= '0;
            filt_q <= '0;
        end else begin
            hist_q <= sync_out;
            filt_q <= (sync_out & hist_q) | (filt_q & (sync_out | hist_q));
        end
    end

    assign ret_data = filt_q;
`else
    assign ret_data = sync_out;
`endif

    assign Y    = y_q;
    assign PD   = pd_q;
    assign RDY  = rdy_q;
    assign BUSY = busy_q;
    assign AOUT = (state_q == ON) ? ret_data : '0;

endmodule

// File: tb/tb_lvshift_bank_seq.sv
// tb/tb_lvshift_bank_seq.sv - directed self-checking bench for lvshift_bank_seq
module tb_lvshift_bank_seq;

    localparam int N_CH        = 8;
    localparam int SETTLE_CYC  = 16;
    localparam int SYNC_STAGES = 2;
`ifdef LVSHIFT_RET_FILTER_EN
    localparam int RET_LAT = SYNC_STAGES + 2;
`else
    localparam int RET_LAT = SYNC_STAGES;
`endif

    logic            CLK = 1'b0;
    logic            RSTN;
    logic            EN;
    logic [N_CH-1:0] A;
    logic [N_CH-1:0] Y;
    logic            PD;
    logic [N_CH-1:0] AIN;
    logic [N_CH-1:0] AOUT;
    logic            RDY;
    logic            BUSY;

    int n_checks = 0;
    int n_errors = 0;

    lvshift_bank_seq #(
        .N_CH        (N_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .A    (A),
        .Y    (Y),
        .PD   (PD),
        .AIN  (AIN),
        .AOUT (AOUT),
        .RDY  (RDY),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one active edge and return to the falling edge, where outputs
    // are sampled and new inputs are driven.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RSTN = 1'b0;
        EN   = 1'b0;
        A    = 8'hFF;
        AIN  = 8'hFF;
        tick();
        tick();
        chk("rst_pd",   32'(PD),   32'd1);
        chk("rst_y",    32'(Y),    32'h00);
        chk("rst_aout", 32'(AOUT), 32'h00);
        chk("rst_rdy",  32'(RDY),  32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RSTN = 1'b1;
        AIN  = 8'h00;
        tick();
        chk("off_idle_pd", 32'(PD), 32'd1);

        // Power-up: EN sampled at edge 0, ON after edge SETTLE_CYC.
        A  = 8'hA5;
        EN = 1'b1;
        tick();
        chk("pu_e0_pd",   32'(PD),   32'd0);
        chk("pu_e0_busy", 32'(BUSY), 32'd1);
        chk("pu_e0_y",    32'(Y),    32'h00);
        for (int i = 1; i < SETTLE_CYC; i++) begin
            tick();
            chk("pu_y_clamped", 32'(Y),   32'h00);
            chk("pu_rdy_low",   32'(RDY), 32'd0);
        end
        tick();
        chk("pu_on_rdy",  32'(RDY),  32'd1);
        chk("pu_on_busy", 32'(BUSY), 32'd0);
        chk("pu_on_y",    32'(Y),    32'hA5);
        chk("pu_on_pd",   32'(PD),   32'd0);

        // Forward path: one cycle from A to Y.
        A = 8'h5A;
        chk("fwd_before", 32'(Y), 32'hA5);
        tick();
        chk("fwd_after", 32'(Y), 32'h5A);

        // Return path latency.
        AIN = 8'h3C;
        for (int i = 1; i < RET_LAT; i++) begin
            tick();
            chk("ret_hold", 32'(AOUT), 32'h00);
        end
        tick();
        chk("ret_arrive", 32'(AOUT), 32'h3C);
`ifdef LVSHIFT_RET_FILTER_EN
        AIN = 8'hFF;
        tick();
        AIN = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ret_glitch", 32'(AOUT), 32'h3C);
        end
`endif

        // Power-down from ON with an EN pulse at edge k+5 that must be ignored.
        EN = 1'b0;
        tick();
        chk("pd_k_rdy",  32'(RDY),  32'd0);
        chk("pd_k_y",    32'(Y),    32'h00);
        chk("pd_k_busy", 32'(BUSY), 32'd1);
        chk("pd_k_pd",   32'(PD),   32'd0);
        chk("pd_k_aout", 32'(AOUT), 32'h00);
        for (int j = 1; j < SETTLE_CYC; j++) begin
            EN = (j == 5);
            tick();
            chk("pd_window_pd",  32'(PD),  32'd0);
            chk("pd_window_rdy", 32'(RDY), 32'd0);
        end
        EN = 1'b0;
        tick();
        chk("pd_end_pd",   32'(PD),   32'd1);
        chk("pd_end_busy", 32'(BUSY), 32'd0);
        tick();
        chk("pd_off_stays", 32'(PD), 32'd1);

        // Abort: EN dropped at PWRUP edge 7.
        EN = 1'b1;
        tick();
        for (int i = 1; i < 7; i++) begin
            tick();
        end
        EN = 1'b0;
        tick();
        chk("abort_busy", 32'(BUSY), 32'd1);
        chk("abort_pd",   32'(PD),   32'd0);
        for (int j = 1; j < SETTLE_CYC; j++) begin
            tick();
            chk("abort_pd_low", 32'(PD),  32'd0);
            chk("abort_no_rdy", 32'(RDY), 32'd0);
        end
        tick();
        chk("abort_pd_rise", 32'(PD),  32'd1);
        chk("abort_rdy",     32'(RDY), 32'd0);

        // Asynchronous reset mid-PWRUP.
        EN = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk("arst_pre_pd", 32'(PD), 32'd0);
        #2;
        RSTN = 1'b0;
        EN   = 1'b0;
        #1;
        chk("arst_pd_async",   32'(PD),   32'd1);
        chk("arst_busy_async", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        chk("arst_off_pd",   32'(PD),   32'd1);
        chk("arst_off_busy", 32'(BUSY), 32'd0);
        chk("arst_off_rdy",  32'(RDY),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
